// File: rtl/nibble_combine_if.sv
// nibble_combine_if
// -----------------
// Bundles the nibble input handshake, the byte-sum output handshake and the
// status outputs of nibble_combine into one interface.
//
// Signals:
//   in_valid  : producer has a nibble sum on in_q/in_hi this cycle
//   in_q      : 5-bit nibble sum, carry in bit 4, legal range 0..30
//   in_hi     : nibble tag, 0 = low-nibble sum, 1 = high-nibble sum
//   in_ready  : combiner can take a nibble this cycle
//   out_ready : consumer takes out_sum this cycle
//   out_valid : out_sum holds a completed byte sum
//   out_sum   : 9-bit reconstructed byte sum, carry in bit 8
//   err       : one-cycle pulse on a protocol violation
//   byte_cnt  : number of byte sums handed to the consumer (wraps at 256)
//
// Modports:
//   master : the side that produces nibbles and consumes byte sums
//   slave  : the combiner itself
interface nibble_combine_if;

    logic       in_valid;
    logic [4:0] in_q;
    logic       in_hi;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [8:0] out_sum;
    logic       err;
    logic [7:0] byte_cnt;

    modport master (
        output in_valid,
        output in_q,
        output in_hi,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  err,
        input  byte_cnt
    );

    modport slave (
        input  in_valid,
        input  in_q,
        input  in_hi,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output err,
        output byte_cnt
    );

endinterface

// File: rtl/nibble_combine.sv
// nibble_combine
// --------------
// Rebuilds a 9-bit byte sum from two separately computed nibble sums. A low
// nibble sum arrives first and is held; the matching high nibble sum is then
// shifted up by four and added to it. The finished sum is held until the
// consumer takes it, after which the byte counter advances.
//
// Out-of-order nibbles and the illegal value 31 are rejected with a single
// registered err pulse.
//
// Ports:
//   clk : rising-edge clock for all state
//   rst : asynchronous, active-high reset
//   nb  : nibble_combine_if.slave
//         inputs  in_valid, in_q[4:0], in_hi, out_ready
//         outputs in_ready, out_valid, out_sum[8:0], err, byte_cnt[7:0]
module nibble_combine (
    input  logic            clk,
    input  logic            rst,
    nibble_combine_if.slave nb
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HAVE_LO = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] lo;
    logic [4:0] lo_nxt;
    logic [8:0] sum;
    logic [8:0] sum_nxt;
    logic       err_q;
    logic       err_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       accept;
    logic       illegal;

    // in_ready is a pure decode of the state; it is only gated by reset so
    // nothing is accepted while the block is held. It never looks at
    // out_ready, so the DONE cycle that hands off the result cannot also
    // swallow a new low nibble.
    assign nb.in_ready  = (state != DONE) && !rst;
    assign nb.out_valid = (state == DONE);
    assign nb.out_sum   = sum;
    assign nb.err       = err_q;
    assign nb.byte_cnt  = cnt;

    assign accept  = nb.in_valid && nb.in_ready;
    assign illegal = (nb.in_q == 5'd31);

    // State register plus the datapath registers that move with it. Reset is
    // asynchronous so a held or partial result disappears the moment rst
    // rises, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lo    <= 5'd0;
            sum   <= 9'd0;
            err_q <= 1'b0;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            lo    <= lo_nxt;
            sum   <= sum_nxt;
            err_q <= err_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and next-datapath decode. Everything holds by default and
    // err defaults low, so err is high for exactly the cycle after a
    // violating accept. An illegal nibble (31) is checked first in every
    // accepting state so it never disturbs the state or the stored low sum.
    // The high nibble is widened to nine bits before the shift, keeping the
    // carry out of the high nibble; the largest legal result is 30 + 480.
    always_comb begin
        state_nxt = state;
        lo_nxt    = lo;
        sum_nxt   = sum;
        err_nxt   = 1'b0;
        cnt_nxt   = cnt;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal || nb.in_hi) begin
                        err_nxt = 1'b1;
                    end else begin
                        lo_nxt    = nb.in_q;
                        state_nxt = HAVE_LO;
                    end
                end
            end

            HAVE_LO: begin
                if (accept) begin
                    if (illegal) begin
                        err_nxt = 1'b1;
                    end else if (!nb.in_hi) begin
                        lo_nxt  = nb.in_q;
                        err_nxt = 1'b1;
                    end else begin
                        sum_nxt   = {4'd0, lo} + {nb.in_q, 4'd0};
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                if (nb.out_ready) begin
                    cnt_nxt   = cnt + 8'd1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_combine.sv
// tb_nibble_combine
// -----------------
// Directed testbench for nibble_combine. Inputs change on the falling edge,
// outputs are sampled 1 ns after the rising edge that should have produced
// them. Expected values are worked out by hand from the nibble arithmetic
// (lo + 16*hi) and the handshake rules.
module tb_nibble_combine;

    logic clk;
    logic rst;

    int checks;
    int failures;

    nibble_combine_if nb ();

    nibble_combine dut (
        .clk (clk),
        .rst (rst),
        .nb  (nb.slave)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a run that never reaches the summary line.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs from the falling edge and returns just after
    // the following rising edge, so registered outputs reflect that edge.
    task automatic applyStimulus(input logic valid, input logic [4:0] q,
                                 input logic hi, input logic ordy);
        @(negedge clk);
        nb.in_valid  = valid;
        nb.in_q      = q;
        nb.in_hi     = hi;
        nb.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse, released on a falling edge.
    task automatic pulseReset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lo_v;
        int hi_v;
        int exp_v;

        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        nb.in_valid  = 1'b0;
        nb.in_q      = 5'd0;
        nb.in_hi     = 1'b0;
        nb.out_ready = 1'b0;

        // Reset state while rst is held high.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(nb.in_ready), 0);
        checkOutput("rst_out_valid", 32'(nb.out_valid), 0);
        checkOutput("rst_out_sum", 32'(nb.out_sum), 0);
        checkOutput("rst_err", 32'(nb.err), 0);
        checkOutput("rst_byte_cnt", 32'(nb.byte_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("post_rst_in_ready", 32'(nb.in_ready), 1);

        // Basic pair: 18 + 15*16 = 258.
        applyStimulus(1'b1, 5'd18, 1'b0, 1'b1);
        checkOutput("basic_lo_err", 32'(nb.err), 0);
        checkOutput("basic_lo_valid", 32'(nb.out_valid), 0);
        applyStimulus(1'b1, 5'd15, 1'b1, 1'b1);
        checkOutput("basic_valid", 32'(nb.out_valid), 1);
        checkOutput("basic_sum", 32'(nb.out_sum), 258);
        checkOutput("basic_in_ready", 32'(nb.in_ready), 0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("basic_cnt", 32'(nb.byte_cnt), 1);
        checkOutput("basic_idle_valid", 32'(nb.out_valid), 0);
        checkOutput("basic_idle_ready", 32'(nb.in_ready), 1);

        // Backpressure: 30 + 30*16 = 510 held for five cycles.
        applyStimulus(1'b1, 5'd30, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd30, 1'b1, 1'b0);
        checkOutput("bp_sum", 32'(nb.out_sum), 510);
        for (int i = 0; i < 5; i++) begin
            // Offer a nibble on odd cycles; it must be ignored while held.
            applyStimulus(1'(i % 2), 5'd1, 1'b0, 1'b0);
            checkOutput("bp_hold_valid", 32'(nb.out_valid), 1);
            checkOutput("bp_hold_sum", 32'(nb.out_sum), 510);
            checkOutput("bp_hold_ready", 32'(nb.in_ready), 0);
            checkOutput("bp_hold_cnt", 32'(nb.byte_cnt), 1);
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("bp_cnt", 32'(nb.byte_cnt), 2);
        checkOutput("bp_idle_valid", 32'(nb.out_valid), 0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("bp_single_cnt", 32'(nb.byte_cnt), 2);

        // High nibble in IDLE is discarded with one err pulse.
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b1);
        checkOutput("idle_hi_err", 32'(nb.err), 1);
        checkOutput("idle_hi_valid", 32'(nb.out_valid), 0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("idle_hi_err_clear", 32'(nb.err), 0);

        // Second low nibble replaces the first: 7 + 1*16 = 23.
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b1);
        checkOutput("lo3_err", 32'(nb.err), 0);
        applyStimulus(1'b1, 5'd7, 1'b0, 1'b1);
        checkOutput("lo7_err", 32'(nb.err), 1);
        checkOutput("lo7_valid", 32'(nb.out_valid), 0);
        applyStimulus(1'b1, 5'd1, 1'b1, 1'b1);
        checkOutput("relo_err", 32'(nb.err), 0);
        checkOutput("relo_valid", 32'(nb.out_valid), 1);
        checkOutput("relo_sum", 32'(nb.out_sum), 23);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("relo_cnt", 32'(nb.byte_cnt), 3);

        // Illegal 31 in HAVE_LO leaves lo=5 intact: 5 + 0*16 = 5.
        applyStimulus(1'b1, 5'd5, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd31, 1'b1, 1'b1);
        checkOutput("ill_err", 32'(nb.err), 1);
        checkOutput("ill_valid", 32'(nb.out_valid), 0);
        checkOutput("ill_ready", 32'(nb.in_ready), 1);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1);
        checkOutput("ill_sum", 32'(nb.out_sum), 5);
        checkOutput("ill_done_valid", 32'(nb.out_valid), 1);
        checkOutput("ill_done_err", 32'(nb.err), 0);

        // Low nibble offered in the handoff cycle must not be taken, so a
        // high nibble right after is a protocol error in IDLE.
        applyStimulus(1'b1, 5'd9, 1'b0, 1'b1);
        checkOutput("handoff_cnt", 32'(nb.byte_cnt), 4);
        checkOutput("handoff_valid", 32'(nb.out_valid), 0);
        applyStimulus(1'b1, 5'd2, 1'b1, 1'b1);
        checkOutput("handoff_hi_err", 32'(nb.err), 1);
        checkOutput("handoff_hi_valid", 32'(nb.out_valid), 0);

        // Illegal 31 tagged low in IDLE: discarded, stays IDLE.
        applyStimulus(1'b1, 5'd31, 1'b0, 1'b1);
        checkOutput("ill_idle_err", 32'(nb.err), 1);
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b1);
        checkOutput("ill_idle_then_hi_err", 32'(nb.err), 1);
        checkOutput("ill_idle_then_hi_valid", 32'(nb.out_valid), 0);

        // Counter wrap: 256 transfers from a fresh reset.
        pulseReset();
        checkOutput("wrap_start_cnt", 32'(nb.byte_cnt), 0);
        for (int i = 0; i < 256; i++) begin
            lo_v  = i % 31;
            hi_v  = (i * 7 + 3) % 31;
            exp_v = lo_v + hi_v * 16;
            applyStimulus(1'b1, 5'(lo_v), 1'b0, 1'b0);
            applyStimulus(1'b1, 5'(hi_v), 1'b1, 1'b0);
            checkOutput("wrap_sum", 32'(nb.out_sum), 32'(exp_v));
            applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
            if (i == 254) checkOutput("wrap_cnt_255", 32'(nb.byte_cnt), 255);
        end
        checkOutput("wrap_cnt_0", 32'(nb.byte_cnt), 0);

        // Reset mid-operation while holding 258 in DONE.
        pulseReset();
        applyStimulus(1'b1, 5'd18, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd15, 1'b1, 1'b0);
        checkOutput("mid_pre_sum", 32'(nb.out_sum), 258);
        checkOutput("mid_pre_valid", 32'(nb.out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(nb.out_valid), 0);
        checkOutput("mid_rst_sum", 32'(nb.out_sum), 0);
        checkOutput("mid_rst_cnt", 32'(nb.byte_cnt), 0);
        checkOutput("mid_rst_ready", 32'(nb.in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b1);
        checkOutput("mid_after_cnt", 32'(nb.byte_cnt), 0);
        checkOutput("mid_after_valid", 32'(nb.out_valid), 0);
        checkOutput("mid_after_ready", 32'(nb.in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_combine.md
NIBBLE_COMBINE -- requirements
Module: nibble_combine

Interface
REQ-001 The block SHALL have exactly one clock and one reset.
REQ-002 Reset SHALL be asynchronous and active-high.
REQ-003 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 Port rst, input, 1 bit: reset (see REQ-002).
REQ-005 Port in_valid, input, 1 bit: in_q/in_hi carry a nibble-sum result this cycle.
REQ-006 Port in_q, input, 5 bits: nibble sum with carry in bit 4. Legal range is 0..30.
REQ-007 Port in_hi, input, 1 bit: nibble tag, where 0 = low-nibble sum and 1 = high-nibble sum.
REQ-008 Port in_ready, output, 1 bit: block can accept a nibble this cycle.
REQ-009 Port out_ready, input, 1 bit: consumer accepts out_sum this cycle.
REQ-010 Port out_valid, output, 1 bit: out_sum holds a completed byte sum.
REQ-011 Port out_sum, output, 9 bits: reconstructed byte sum with carry in bit 8.
REQ-012 Port err, output, 1 bit: one-cycle pulse on a protocol violation.
REQ-013 Port byte_cnt, output, 8 bits: count of byte sums delivered to the consumer.

Function
REQ-014 A nibble SHALL be accepted on a rising edge only when in_valid=1 and in_ready=1; an output SHALL be transferred only when out_valid=1 and out_ready=1.
REQ-015 The FSM SHALL have exactly three states: IDLE (waiting for low nibble), HAVE_LO (low nibble stored), DONE (result held).
REQ-016 in_ready SHALL be 1 in IDLE and HAVE_LO, 0 in DONE; in_ready SHALL be a decode of state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 IDLE, accept with in_hi=0 and in_q<=30: store in_q as lo, go to HAVE_LO.
REQ-019 HAVE_LO, accept with in_hi=1 and in_q<=30: register out_sum = lo + (in_q << 4) at full 9-bit width, go to DONE. out_valid SHALL be 1 in the cycle right after the accepting edge (latency 1).
REQ-020 HAVE_LO, accept with in_hi=0 and in_q<=30: replace lo with the new in_q, stay in HAVE_LO, and pulse err.
REQ-021 IDLE, accept with in_hi=1: discard the nibble, stay in IDLE, pulse err.
REQ-022 Any accepted nibble with in_q=31 (illegal) SHALL be discarded with no state or lo change, and SHALL pulse err.
REQ-023 DONE: out_sum SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 DONE with out_ready=1: go to IDLE and increment byte_cnt by 1. byte_cnt SHALL wrap from 255 to 0.
REQ-025 No nibble SHALL be accepted in the DONE cycle in which out_ready=1; the next low nibble SHALL be accepted no earlier than the following cycle.
REQ-026 err SHALL be registered, high for exactly one cycle per violating accept, and 0 otherwise.
REQ-027 in_valid=0 SHALL never change state, lo, out_sum or byte_cnt.
REQ-028 With legal inputs out_sum SHALL lie in 0..510; no saturation SHALL be applied.

Reset
REQ-029 While rst=1, and immediately on its assertion, the block SHALL force: state=IDLE, lo=0, out_sum=0, out_valid=0, err=0, byte_cnt=0.
REQ-030 While rst=1, in_ready SHALL be 0; after deassertion, in_ready SHALL be 1 from the first clock edge.
REQ-031 Reset asserted in HAVE_LO or DONE SHALL drop the partial or held result with no output transfer and no byte_cnt increment.

Verification
REQ-032 Scenario, basic pair: lo in_q=18 (in_hi=0), then hi in_q=15 (in_hi=1), out_ready=1 -> out_valid one cycle after the hi accept, out_sum=258, byte_cnt=1.
REQ-033 Scenario, backpressure: lo=30, hi=30, out_ready=0 for 5 cycles, then 1 -> out_sum=510 held stable with in_ready=0 for 5 cycles; then a single transfer and return to IDLE.
REQ-034 Scenario, protocol errors: hi in_q=4 sent in IDLE -> err pulses once, state stays IDLE. lo=3, then lo=7, then hi=1 -> one err pulse on the second lo, then out_sum=23.
REQ-035 Scenario, illegal value: in HAVE_LO with lo=5, send in_q=31 -> err pulses, state stays HAVE_LO; then hi=0 -> out_sum=5.
REQ-036 Scenario, counter wrap: 256 back-to-back byte transfers -> byte_cnt reads 0 after the 256th transfer.
REQ-037 Scenario, reset mid-operation: assert rst asynchronously (between clock edges) while in DONE with out_sum=258 -> out_valid and out_sum go to 0 at once, byte_cnt is unchanged from its pre-DONE value of 0.
